fifo_drain_arbiter: RTL and testbench
=====================================

Name: fifo_drain_arbiter

Overview:
Round-robin scheduler that drains NUM_REQ upstream fall-through FIFOs into a single registered valid/ready output stream. Each upstream FIFO presents head data while not empty. The arbiter returns one pop pulse per transfer and tags each output beat with its source index. Burst-hold keeps a grant on one FIFO for up to MAX_BURST consecutive beats, which reduces source interleaving toward downstream consumers such as the commit and writeback paths.

Parameters:
NUM_REQ, 4, number of upstream FIFOs (2..16)
DATA_WIDTH, 32, data bits per entry
MAX_BURST, 4, max consecutive beats granted to one FIFO before rotation (>=1)
IDX_W, $clog2(NUM_REQ), source index width; derived, never overridden

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
flush_i  in  1  synchronous flush: drops output beat, ends burst
fifo_empty_i  in  NUM_REQ  per-FIFO empty flag
fifo_data_i  in  NUM_REQ*DATA_WIDTH  per-FIFO head data, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
fifo_pop_o  out  NUM_REQ  one-hot-or-zero pop strobe
out_valid_o  out  1  output beat valid
out_ready_i  in  1  downstream accepts beat
out_data_o  out  DATA_WIDTH  registered beat data
out_src_o  out  IDX_W  index of FIFO the beat came from
busy_o  out  1  high when state is BURST or out_valid_o is high

Behaviour:
- Reset (rst_i=1 at edge): out_valid_o=0, out_data_o=0, out_src_o=0, state=IDLE, rr_ptr=0, cur=0, burst_cnt=0. fifo_pop_o is 0 while rst_i=1.
- load_en = ~out_valid_o | out_ready_i. The output is a single register and never pops unless load_en=1.
- fifo_pop_o is combinational from fifo_empty_i, state, and out_ready_i. At most one bit is set. A bit is never set for a FIFO with empty=1.
- On a pop of FIFO k at an edge: out_data_o <= data[k], out_src_o <= k, out_valid_o <= 1. Latency from pop to visible beat is 1 cycle.
- If load_en=1 and there is no pop: out_valid_o <= 0 (beat consumed). If load_en=0: all output registers hold.
- IDLE: search indices rr_ptr, rr_ptr+1, ... (mod NUM_REQ) and pick the first non-empty FIFO k.
  - If load_en: pop k, cur<=k, burst_cnt<=1.
  - If MAX_BURST>1: go to BURST. Otherwise stay IDLE with rr_ptr<=k+1 mod NUM_REQ.
  - If no FIFO is non-empty: no pop, stay IDLE.
- BURST, with load_en=1:
  - fifo_empty_i[cur]=0: pop cur, burst_cnt++. If the new count equals MAX_BURST: go to IDLE, rr_ptr<=cur+1 mod NUM_REQ.
  - fifo_empty_i[cur]=1: the burst ends and rr_ptr<=cur+1. The IDLE search from cur+1 is performed in the same cycle, with its pop and new burst start, so there is no bubble.
- BURST, load_en=0: hold state, cur, and burst_cnt.
- Wrap-around: rr_ptr and the search wrap modulo NUM_REQ, including non-power-of-2 NUM_REQ.
- flush_i=1 (rst_i=0): fifo_pop_o=0 that cycle; out_valid_o<=0, state<=IDLE, burst_cnt<=0. rr_ptr and out_data_o hold.
- Priority: rst_i over flush_i over normal operation.
- A FIFO going empty mid-burst is covered by the burst-end rule above.

Optional Feature:
FIFO_DRAIN_ARB_STATS_EN:
- Defined: adds output stat_pop_cnt_o [31:0], which counts total pops and saturates at 32'hFFFF_FFFF.
- Also adds stat_stall_cnt_o [31:0], which counts cycles with out_valid_o=1 & out_ready_i=0 and saturates.
- Both counters are cleared by rst_i only; flush_i does not clear them.
- Undefined: neither port nor counter exists.

Test Plan:
All scenarios use NUM_REQ=4, MAX_BURST=4.
1. rst_i=1 for 2 cycles, all FIFOs non-empty, out_ready_i=1 -> fifo_pop_o=0, out_valid_o=0, out_data_o=0, busy_o=0 throughout.
2. Only FIFO2 holds 6 entries 0xA0..0xA5, out_ready_i=1 -> 6 back-to-back pops on bit 2. Beats 0xA0..0xA5 appear on consecutive cycles starting 1 cycle after the first pop, out_src_o=2, with no bubble at the burst-4 boundary.
3. All FIFOs hold 8 entries, out_ready_i=1 -> out_src_o sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,0,0,0...
4. Mid-burst (burst_cnt=2 on FIFO1), out_ready_i=0 for 5 cycles -> fifo_pop_o=0 and out_data_o stable. After release, 2 more FIFO1 beats follow, then rotation to FIFO2.
5. FIFO0 has 2 entries, FIFO1 has 5, others empty -> out_src_o = 0,0,1,1,1,1,1 with no idle cycle between sources.
6. flush_i pulsed while out_valid_o=1 mid-burst -> that cycle fifo_pop_o=0, next cycle out_valid_o=0 and busy_o=0. Next grant restarts from the held rr_ptr. With FIFO_DRAIN_ARB_STATS_EN, stat_pop_cnt_o equals the number of pops issued and is not cleared by the flush.

Source files
------------

// File: rtl/fifo_drain_arbiter_if.sv
// Upstream FIFO heads plus the downstream valid/ready beat stream of fifo_drain_arbiter.
// master = arbiter side, slave = FIFO bank / downstream consumer side.
interface fifo_drain_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            fifo_empty_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] fifo_data_i;
    logic [NUM_REQ-1:0]            fifo_pop_o;
    logic                          out_valid_o;
    logic                          out_ready_i;
    logic [DATA_WIDTH-1:0]         out_data_o;
    logic [IDX_W-1:0]              out_src_o;

    modport master (
        input  fifo_empty_i, fifo_data_i, out_ready_i,
        output fifo_pop_o, out_valid_o, out_data_o, out_src_o
    );

    modport slave (
        output fifo_empty_i, fifo_data_i, out_ready_i,
        input  fifo_pop_o, out_valid_o, out_data_o, out_src_o
    );
endinterface

// File: rtl/fifo_drain_arbiter.sv
// Round-robin burst-hold drain of NUM_REQ fall-through FIFOs into one registered beat stream.
// Optional FIFO_DRAIN_ARB_STATS_EN adds saturating pop and stall counters.
module fifo_drain_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    fifo_drain_arbiter_if.master   bus,
    output logic                   busy_o
`ifdef FIFO_DRAIN_ARB_STATS_EN
    ,
    output logic [31:0]            stat_pop_cnt_o,
    output logic [31:0]            stat_stall_cnt_o
`endif
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       cur_q, cur_d;
    logic [CNT_W-1:0]       burst_cnt_q, burst_cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [IDX_W-1:0]       out_src_q, out_src_d;

    logic                   load_en;
    logic                   run;
    logic                   pop_en;
    logic [IDX_W-1:0]       pop_idx;
    logic                   start_en;
    logic [IDX_W-1:0]       start_idx;
    logic [IDX_W:0]         pick_rr;
    logic [IDX_W:0]         pick_nxt;
    logic [CNT_W-1:0]       burst_inc;
    logic [NUM_REQ-1:0]     pop_vec;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (32'(idx) == 32'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    // {found, index} of the first non-empty FIFO at or after start, modulo NUM_REQ
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] empty,
                                               input logic [IDX_W-1:0]   start);
        logic [IDX_W:0] res;
        int unsigned    idx;
        res = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(start) + i) % 32'(NUM_REQ);
            if (!res[IDX_W] && !empty[idx]) begin
                res = {1'b1, IDX_W'(idx)};
            end
        end
        return res;
    endfunction

    assign load_en = ~out_valid_q | bus.out_ready_i;
    assign run     = ~rst_i & ~flush_i & load_en;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cur_q       <= '0;
            burst_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_q       <= cur_d;
            burst_cnt_q <= burst_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_d       = cur_q;
        burst_cnt_d = burst_cnt_q;
        pop_en      = 1'b0;
        pop_idx     = cur_q;
        start_en    = 1'b0;
        pick_rr     = rr_pick(bus.fifo_empty_i, rr_ptr_q);
        pick_nxt    = rr_pick(bus.fifo_empty_i, wrap_inc(cur_q));
        start_idx   = pick_rr[IDX_W-1:0];
        burst_inc   = burst_cnt_q + 1'b1;

        if (flush_i) begin
            state_d     = IDLE;
            burst_cnt_d = '0;
        end

        if (run) begin
            unique case (state_q)
                IDLE: start_en = pick_rr[IDX_W];
                BURST: begin
                    if (!bus.fifo_empty_i[cur_q]) begin
                        pop_en      = 1'b1;
                        pop_idx     = cur_q;
                        burst_cnt_d = burst_inc;
                        if (burst_inc == CNT_W'(MAX_BURST)) begin
                            state_d  = IDLE;
                            rr_ptr_d = wrap_inc(cur_q);
                        end
                    end else begin
                        // Source ran dry: rotate past it and grant the next one this cycle.
                        state_d   = IDLE;
                        rr_ptr_d  = wrap_inc(cur_q);
                        start_en  = pick_nxt[IDX_W];
                        start_idx = pick_nxt[IDX_W-1:0];
                    end
                end
            endcase

            if (start_en) begin
                pop_en      = 1'b1;
                pop_idx     = start_idx;
                cur_d       = start_idx;
                burst_cnt_d = CNT_W'(1);
                if (MAX_BURST > 1) begin
                    state_d = BURST;
                end else begin
                    state_d  = IDLE;
                    rr_ptr_d = wrap_inc(start_idx);
                end
            end
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (pop_en) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.fifo_data_i[32'(pop_idx)*DATA_WIDTH +: DATA_WIDTH];
            out_src_d   = pop_idx;
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        pop_vec = '0;
        if (pop_en) begin
            pop_vec[pop_idx] = 1'b1;
        end
        busy_o = (state_q == BURST) | out_valid_q;
    end

    assign bus.fifo_pop_o  = pop_vec;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_data_q;
    assign bus.out_src_o   = out_src_q;

`ifdef FIFO_DRAIN_ARB_STATS_EN
    logic [31:0] stat_pop_cnt_q, stat_pop_cnt_d;
    logic [31:0] stat_stall_cnt_q, stat_stall_cnt_d;

    always_comb begin
        stat_pop_cnt_d   = stat_pop_cnt_q;
        stat_stall_cnt_d = stat_stall_cnt_q;
        if (pop_en && stat_pop_cnt_q != '1) begin
            stat_pop_cnt_d = stat_pop_cnt_q + 32'd1;
        end
        if (out_valid_q && !bus.out_ready_i && stat_stall_cnt_q != '1) begin
            stat_stall_cnt_d = stat_stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_pop_cnt_q   <= '0;
            stat_stall_cnt_q <= '0;
        end else begin
            stat_pop_cnt_q   <= stat_pop_cnt_d;
            stat_stall_cnt_q <= stat_stall_cnt_d;
        end
    end

    assign stat_pop_cnt_o   = stat_pop_cnt_q;
    assign stat_stall_cnt_o = stat_stall_cnt_q;
`endif
endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Directed bench for fifo_drain_arbiter (NUM_REQ=4, MAX_BURST=4) with queue-modelled upstream FIFOs.
module tb_fifo_drain_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic busy;
`ifdef FIFO_DRAIN_ARB_STATS_EN
    logic [31:0] stat_pop;
    logic [31:0] stat_stall;
`endif

    fifo_drain_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    fifo_drain_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus),
        .busy_o  (busy)
`ifdef FIFO_DRAIN_ARB_STATS_EN
        ,
        .stat_pop_cnt_o   (stat_pop),
        .stat_stall_cnt_o (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic [31:0] q3[$];
    logic [3:0]  pop_seen;
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic push(input int f, input logic [31:0] v);
        case (f)
            0: q0.push_back(v);
            1: q1.push_back(v);
            2: q2.push_back(v);
            default: q3.push_back(v);
        endcase
    endtask

    task automatic refresh();
        bus.fifo_empty_i[0]      = (q0.size() == 0);
        bus.fifo_empty_i[1]      = (q1.size() == 0);
        bus.fifo_empty_i[2]      = (q2.size() == 0);
        bus.fifo_empty_i[3]      = (q3.size() == 0);
        bus.fifo_data_i[31:0]    = (q0.size() != 0) ? q0[0] : 32'h0;
        bus.fifo_data_i[63:32]   = (q1.size() != 0) ? q1[0] : 32'h0;
        bus.fifo_data_i[95:64]   = (q2.size() != 0) ? q2[0] : 32'h0;
        bus.fifo_data_i[127:96]  = (q3.size() != 0) ? q3[0] : 32'h0;
    endtask

    // One clock: sample pops just before the edge, retire popped heads just after it.
    task automatic step();
        #1 pop_seen = bus.fifo_pop_o;
        @(posedge clk);
        #1;
        if (pop_seen[0] && q0.size() != 0) void'(q0.pop_front());
        if (pop_seen[1] && q1.size() != 0) void'(q1.pop_front());
        if (pop_seen[2] && q2.size() != 0) void'(q2.pop_front());
        if (pop_seen[3] && q3.size() != 0) void'(q3.pop_front());
        refresh();
        @(negedge clk);
    endtask

    task automatic beat(input int s, input logic [31:0] d);
        step();
        chk("beat_valid", 32'(bus.out_valid_o), 32'd1);
        chk("beat_src", 32'(bus.out_src_o), 32'(s));
        chk("beat_data", bus.out_data_o, d);
    endtask

    task automatic expect_idle();
        step();
        chk("idle_valid", 32'(bus.out_valid_o), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        flush           = 1'b0;
        bus.out_ready_i = 1'b1;
        for (int f = 0; f < 4; f++) begin
            for (int j = 0; j < 8; j++) push(f, 32'(f * 16 + j));
        end
        refresh();
        @(negedge clk);

        // Reset held two cycles with every FIFO non-empty
        for (int c = 0; c < 2; c++) begin
            if (c > 0) step();
            chk("rst_pop", 32'(bus.fifo_pop_o), 32'd0);
            chk("rst_valid", 32'(bus.out_valid_o), 32'd0);
            chk("rst_data", bus.out_data_o, 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        rst = 1'b0;

        // Full round robin: four-beat bursts 0,1,2,3 then back to 0
        for (int n = 0; n < 20; n++) begin
            beat((n / 4) % 4, 32'(((n / 4) % 4) * 16 + ((n >= 16) ? 4 : 0) + n % 4));
        end
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        refresh();
        expect_idle();

        // Lone FIFO2 with six entries: continuous across the burst boundary
        for (int j = 0; j < 6; j++) push(2, 32'hA0 + 32'(j));
        refresh();
        for (int n = 0; n < 6; n++) begin
            beat(2, 32'hA0 + 32'(n));
            chk("solo_pop", 32'(pop_seen), 32'h4);
        end
        expect_idle();

        // Backpressure mid-burst on FIFO1 (rr_ptr now 3)
        for (int j = 0; j < 4; j++) push(1, 32'hB0 + 32'(j));
        push(2, 32'hC0);
        push(2, 32'hC1);
        refresh();
        beat(1, 32'hB0);
        beat(1, 32'hB1);
        bus.out_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("stall_pop", 32'(pop_seen), 32'd0);
            chk("stall_data", bus.out_data_o, 32'hB1);
            chk("stall_valid", 32'(bus.out_valid_o), 32'd1);
            chk("stall_busy", 32'(busy), 32'd1);
        end
        bus.out_ready_i = 1'b1;
        beat(1, 32'hB2);
        beat(1, 32'hB3);
        beat(2, 32'hC0);
        beat(2, 32'hC1);

        // FIFO0 short, FIFO1 longer: hand-off without a bubble
        push(0, 32'hD0);
        push(0, 32'hD1);
        for (int j = 0; j < 5; j++) push(1, 32'hE0 + 32'(j));
        refresh();
        beat(0, 32'hD0);
        beat(0, 32'hD1);
        for (int j = 0; j < 5; j++) beat(1, 32'hE0 + 32'(j));
        expect_idle();

        // Flush mid-burst on FIFO2 (rr_ptr now 2); FIFO0 loaded to expose a lost rr_ptr
        for (int j = 0; j < 6; j++) push(2, 32'hF0 + 32'(j));
        push(3, 32'h30);
        push(3, 32'h31);
        push(0, 32'h0E);
        refresh();
        beat(2, 32'hF0);
        beat(2, 32'hF1);
        flush = 1'b1;
        #1 chk("flush_pop", 32'(bus.fifo_pop_o), 32'd0);
        step();
        flush = 1'b0;
        chk("flush_valid", 32'(bus.out_valid_o), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_data_hold", bus.out_data_o, 32'hF1);
`ifdef FIFO_DRAIN_ARB_STATS_EN
        chk("stat_pop_after_flush", stat_pop, 32'd41);
`endif
        for (int j = 2; j < 6; j++) beat(2, 32'hF0 + 32'(j));
        beat(3, 32'h30);
        beat(3, 32'h31);
        beat(0, 32'h0E);
        expect_idle();
`ifdef FIFO_DRAIN_ARB_STATS_EN
        chk("stat_pop_final", stat_pop, 32'd48);
        chk("stat_stall_final", stat_stall, 32'd5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
